// File: rtl/sat_cmd_sequencer.sv
// Command sequencer for the SAT accelerator array: buffers a literal stream in a
// small FIFO and serialises it into RESET_CNF / LIT / END_CLAUSE command bytes.
module sat_cmd_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int RESULT_LAT = 3,
  parameter int VAR_W      = 5
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic             lit_valid,
  output logic             lit_ready,
  input  logic [VAR_W-1:0] lit_var,
  input  logic             lit_neg,
  input  logic             lit_eoc,
  input  logic             lit_eof,
  output logic [7:0]       command,
  input  logic             sat_in,
  output logic             busy,
  output logic             done,
  output logic             sat_result
);

  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW      = (RESULT_LAT > 1) ? $clog2(RESULT_LAT + 1) : 1;
  localparam int ENTRY_W = VAR_W + 3;
  localparam logic [AW:0] CNT_FULL  = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  CMD_NOP   = 8'h00;
  localparam logic [7:0]  CMD_ENDC  = 8'h80;
  localparam logic [7:0]  CMD_RESET = 8'hC0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    STREAM = 3'd2,
    ENDC   = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } stateT;

  // Each state names what is on the command bus during that cycle.
  stateT               state, stateNext;
  logic [ENTRY_W-1:0]  fifoMem [FIFO_DEPTH];
  logic [ENTRY_W-1:0]  head;
  logic [AW-1:0]       wrPtr, rdPtr;
  logic [AW:0]         count, countNext;
  logic                eofSeen, eofSeenNext;
  logic                lastEoc, lastEof;
  logic [CW-1:0]       waitCnt, waitCntNext;
  logic [7:0]          cmdNext;
  logic                satNext, readyNext, busyNext;
  logic                tryPop, doPop, doPush;

  assign head   = fifoMem[rdPtr];
  assign doPush = lit_valid && lit_ready;

  // Next-state, command and FIFO bookkeeping decode.
  always_comb begin
    stateNext   = state;
    cmdNext     = CMD_NOP;
    tryPop      = 1'b0;
    doPop       = 1'b0;
    waitCntNext = waitCnt;
    satNext     = sat_result;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = INIT;
          cmdNext   = CMD_RESET;
        end else begin
          stateNext = IDLE;
        end
      end
      INIT: begin
        stateNext = STREAM;
        tryPop    = 1'b1;
      end
      STREAM: begin
        if (lastEoc) begin
          stateNext = ENDC;
          cmdNext   = CMD_ENDC;
        end else begin
          stateNext = STREAM;
          tryPop    = 1'b1;
        end
      end
      ENDC: begin
        if (lastEof) begin
          stateNext   = WAIT;
          waitCntNext = CW'(RESULT_LAT - 1);
        end else begin
          stateNext = STREAM;
          tryPop    = 1'b1;
        end
      end
      WAIT: begin
        if (waitCnt == '0) begin
          stateNext = DONE;
          satNext   = sat_in;
        end else begin
          waitCntNext = waitCnt - CW'(1);
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // A LIT cycle only starts when an entry is actually buffered; otherwise NOP.
    if (tryPop && (count != '0)) begin
      doPop   = 1'b1;
      cmdNext = {2'b01, head[VAR_W:0]};
    end else begin
      doPop   = 1'b0;
    end

    countNext = count + {{AW{1'b0}}, doPush} - {{AW{1'b0}}, doPop};

    if (state == DONE) begin
      eofSeenNext = 1'b0;
    end else if (doPush && lit_eof) begin
      eofSeenNext = 1'b1;
    end else begin
      eofSeenNext = eofSeen;
    end

    readyNext = (countNext != CNT_FULL) && !eofSeenNext &&
                (stateNext inside {IDLE, INIT, STREAM});
    busyNext  = stateNext inside {INIT, STREAM, ENDC, WAIT};
  end

  // Literal storage; pointers and count carry the reset, the array does not.
  always_ff @(posedge clk) begin
    if (doPush) begin
      fifoMem[wrPtr] <= {lit_eof, lit_eoc | lit_eof, lit_neg, lit_var};
    end
  end

  // State, pointers and all registered outputs.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state      <= IDLE;
      command    <= CMD_NOP;
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      eofSeen    <= 1'b0;
      lastEoc    <= 1'b0;
      lastEof    <= 1'b0;
      waitCnt    <= '0;
      lit_ready  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sat_result <= 1'b0;
    end else begin
      state      <= stateNext;
      command    <= cmdNext;
      wrPtr      <= doPush ? wrPtr + AW'(1) : wrPtr;
      rdPtr      <= doPop ? rdPtr + AW'(1) : rdPtr;
      count      <= countNext;
      eofSeen    <= eofSeenNext;
      lastEoc    <= doPop && head[VAR_W+1];
      lastEof    <= doPop ? head[VAR_W+2] : lastEof;
      waitCnt    <= waitCntNext;
      lit_ready  <= readyNext;
      busy       <= busyNext;
      done       <= (stateNext == DONE);
      sat_result <= satNext;
    end
  end

endmodule

// File: tb/tb_sat_cmd_sequencer.sv
// Self-checking bench for sat_cmd_sequencer: directed scenarios plus random formulas
// checked against a clause-level model of the expected command stream.
module tb_sat_cmd_sequencer;
  localparam int DEPTH = 8;
  localparam int LAT   = 3;

  logic       clk = 1'b0, resetN = 1'b0, start = 1'b0, lit_valid = 1'b0;
  logic [4:0] lit_var = 5'd0;
  logic       lit_neg = 1'b0, lit_eoc = 1'b0, lit_eof = 1'b0, sat_in = 1'b0;
  logic       lit_ready, busy, done, sat_result;
  logic [7:0] command;

  int errors = 0, checks = 0;
  int cyc = 0, endcLeft = 0, endcCyc = -100, doneCnt = 0, doneCyc = 0;
  bit satWant = 1'b0, logOn = 1'b0;
  logic [7:0] fullQ[$], seenQ[$], expQ[$];
  logic [4:0] fVar [16];
  logic       fNeg [16], fEoc [16], fEof [16];
  int         fLen = 0, fClauses = 0;

  always #5 clk = ~clk;

  sat_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .RESULT_LAT(LAT), .VAR_W(5)) dut (
    .clk(clk), .resetN(resetN), .start(start), .lit_valid(lit_valid), .lit_ready(lit_ready),
    .lit_var(lit_var), .lit_neg(lit_neg), .lit_eoc(lit_eoc), .lit_eof(lit_eof),
    .command(command), .sat_in(sat_in), .busy(busy), .done(done), .sat_result(sat_result)
  );

  // Observe outputs just after each edge; drive sat_in valid only in the sample cycle.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (logOn) begin
      fullQ.push_back(command);
      if (command != 8'h00) seenQ.push_back(command);
    end
    if (command == 8'h80 && endcLeft > 0) begin
      endcLeft--;
      if (endcLeft == 0) endcCyc = cyc;
    end
    if (done === 1'b1) begin
      doneCnt++;
      doneCyc = cyc;
    end
    sat_in = (endcLeft == 0 && cyc == endcCyc + LAT) ? satWant : !satWant;
  end

  // Reference: RESET_CNF, one LIT per literal, END_CLAUSE after each eoc/eof literal.
  task automatic buildModel();
    expQ.delete();
    expQ.push_back(8'hC0);
    fClauses = 0;
    for (int i = 0; i < fLen; i++) begin
      expQ.push_back(8'h40 + (fNeg[i] ? 8'h20 : 8'h00) + {3'b000, fVar[i]});
      if (fEoc[i] || fEof[i]) begin
        expQ.push_back(8'h80);
        fClauses++;
      end
    end
  endtask

  task automatic armRun(input bit want);
    fullQ.delete();
    seenQ.delete();
    satWant  = want;
    endcLeft = fClauses;
    logOn    = 1'b1;
  endtask

  task automatic setLit(input int i, input logic [4:0] v, input logic n, input logic c, input logic f);
    fVar[i] = v; fNeg[i] = n; fEoc[i] = c; fEof[i] = f;
  endtask

  task automatic pushLit(input int i, output bit ok);
    ok = 1'b0;
    lit_var = fVar[i]; lit_neg = fNeg[i]; lit_eoc = fEoc[i]; lit_eof = fEof[i];
    lit_valid = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      if (lit_ready === 1'b1) ok = 1'b1;
      @(negedge clk);
    end
    lit_valid = 1'b0;
  endtask

  task automatic pushRange(input int lo, input int hi, input bit gaps, output bit ok);
    bit one;
    ok = 1'b1;
    for (int i = lo; i < hi; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      pushLit(i, one);
      if (!one) ok = 1'b0;
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int base, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 400 && !ok; t++) begin
      @(negedge clk);
      if (doneCnt > base) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (command !== 8'h00) begin errors++; $display("FAIL reset_command: got %h want 00", command); end
    checks++; if (lit_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", lit_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (sat_result !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", sat_result); end
    resetN = 1'b1;
    @(negedge clk);
    checks++; if (lit_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b want 1", lit_ready); end
  endtask

  task automatic test_single_clause();
    bit ok, okd;
    int base;
    fLen = 2;
    setLit(0, 5'd3, 1'b0, 1'b0, 1'b0);
    setLit(1, 5'd7, 1'b1, 1'b1, 1'b1);
    buildModel();
    for (int i = 0; i < LAT + 1; i++) expQ.push_back(8'h00);
    pushRange(0, 2, 1'b0, ok);
    armRun(1'b1);
    base = doneCnt;
    pulseStart();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
    waitDone(base, okd);
    checks++; if (!(ok && okd)) begin errors++; $display("FAIL single_timeout: push %b done %b want 1 1", ok, okd); end
    checks++; if (fullQ.size() < expQ.size()) begin errors++; $display("FAIL single_len: got %0d want %0d", fullQ.size(), expQ.size()); end
    else for (int i = 0; i < expQ.size(); i++) begin
      checks++; if (fullQ[i] !== expQ[i]) begin errors++; $display("FAIL single_cmd[%0d]: got %h want %h", i, fullQ[i], expQ[i]); end
    end
    checks++; if (sat_result !== 1'b1) begin errors++; $display("FAIL single_sat: got %b want 1", sat_result); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_done: got %b want 0", busy); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_width: got %b want 0", done); end
    checks++; if (doneCnt - base !== 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", doneCnt - base); end
  endtask

  task automatic test_two_clauses();
    bit ok, okd;
    int base;
    fLen = 3;
    setLit(0, 5'd1, 1'b0, 1'b0, 1'b0);
    setLit(1, 5'd2, 1'b0, 1'b1, 1'b0);
    setLit(2, 5'd0, 1'b1, 1'b1, 1'b1);
    buildModel();
    armRun(1'b0);
    base = doneCnt;
    pulseStart();
    pushRange(0, 3, 1'b1, ok);
    waitDone(base, okd);
    checks++; if (!(ok && okd)) begin errors++; $display("FAIL two_timeout: push %b done %b want 1 1", ok, okd); end
    checks++; if (seenQ.size() !== expQ.size()) begin errors++; $display("FAIL two_len: got %0d want %0d", seenQ.size(), expQ.size()); end
    else for (int i = 0; i < expQ.size(); i++) begin
      checks++; if (seenQ[i] !== expQ[i]) begin errors++; $display("FAIL two_cmd[%0d]: got %h want %h", i, seenQ[i], expQ[i]); end
    end
    checks++; if (sat_result !== 1'b0) begin errors++; $display("FAIL two_sat: got %b want 0", sat_result); end
    checks++; if (doneCyc - endcCyc !== LAT + 1) begin errors++; $display("FAIL two_latency: got %0d want %0d", doneCyc - endcCyc, LAT + 1); end
  endtask

  task automatic test_fifo_full();
    bit ok, ok2, okd;
    int base;
    fLen = 12;
    for (int i = 0; i < 12; i++) setLit(i, 5'(i + 2), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    fEoc[11] = 1'b1; fEof[11] = 1'b1;
    buildModel();
    armRun(1'b1);
    pushRange(0, DEPTH, 1'b0, ok);
    checks++; if (lit_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", lit_ready); end
    base = doneCnt;
    pulseStart();
    pushRange(DEPTH, 12, 1'b0, ok2);
    waitDone(base, okd);
    checks++; if (!(ok && ok2 && okd)) begin errors++; $display("FAIL full_timeout: push %b %b done %b want 1 1 1", ok, ok2, okd); end
    checks++; if (seenQ.size() !== expQ.size()) begin errors++; $display("FAIL full_len: got %0d want %0d", seenQ.size(), expQ.size()); end
    else for (int i = 0; i < expQ.size(); i++) begin
      checks++; if (seenQ[i] !== expQ[i]) begin errors++; $display("FAIL full_cmd[%0d]: got %h want %h", i, seenQ[i], expQ[i]); end
    end
  endtask

  task automatic test_start_while_busy();
    bit ok, ok2, okd;
    int base;
    fLen = 4;
    setLit(0, 5'd4, 1'b0, 1'b0, 1'b0);
    setLit(1, 5'd9, 1'b0, 1'b1, 1'b0);
    setLit(2, 5'd12, 1'b1, 1'b0, 1'b0);
    setLit(3, 5'd30, 1'b1, 1'b0, 1'b1);
    buildModel();
    armRun(1'b1);
    base = doneCnt;
    pulseStart();
    pushRange(0, 2, 1'b0, ok);
    pulseStart();
    pushRange(2, 4, 1'b1, ok2);
    waitDone(base, okd);
    repeat (5) @(negedge clk);
    checks++; if (!(ok && ok2 && okd)) begin errors++; $display("FAIL busy_timeout: push %b %b done %b want 1 1 1", ok, ok2, okd); end
    checks++; if (doneCnt - base !== 1) begin errors++; $display("FAIL busy_done_count: got %0d want 1", doneCnt - base); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_restart: got %b want 0", busy); end
    checks++; if (seenQ.size() !== expQ.size()) begin errors++; $display("FAIL busy_len: got %0d want %0d", seenQ.size(), expQ.size()); end
    else for (int i = 0; i < expQ.size(); i++) begin
      checks++; if (seenQ[i] !== expQ[i]) begin errors++; $display("FAIL busy_cmd[%0d]: got %h want %h", i, seenQ[i], expQ[i]); end
    end
  endtask

  task automatic test_reset_mid_run();
    bit ok, seen, okd;
    int base;
    fLen = 3;
    setLit(0, 5'd5, 1'b0, 1'b0, 1'b0);
    setLit(1, 5'd6, 1'b1, 1'b0, 1'b0);
    setLit(2, 5'd8, 1'b0, 1'b1, 1'b1);
    buildModel();
    pushRange(0, 3, 1'b0, ok);
    armRun(1'b0);
    base = doneCnt;
    pulseStart();
    seen = 1'b0;
    for (int t = 0; t < 100 && !seen; t++) begin
      @(negedge clk);
      if (endcLeft == 0) seen = 1'b1;
    end
    @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    checks++; if (!(ok && seen)) begin errors++; $display("FAIL rst_timeout: push %b endc %b want 1 1", ok, seen); end
    checks++; if (command !== 8'h00) begin errors++; $display("FAIL rst_command: got %h want 00", command); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (sat_result !== 1'b0) begin errors++; $display("FAIL rst_sat: got %b want 0", sat_result); end
    checks++; if (lit_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", lit_ready); end
    resetN = 1'b1;
    repeat (6) @(negedge clk);
    checks++; if (doneCnt !== base) begin errors++; $display("FAIL rst_no_done: got %0d want %0d", doneCnt, base); end
    fLen = 2;
    setLit(0, 5'd17, 1'b1, 1'b1, 1'b0);
    setLit(1, 5'd18, 1'b0, 1'b1, 1'b1);
    buildModel();
    armRun(1'b1);
    pushRange(0, 2, 1'b0, ok);
    pulseStart();
    waitDone(base, okd);
    checks++; if (!(ok && okd)) begin errors++; $display("FAIL rst_fresh_timeout: push %b done %b want 1 1", ok, okd); end
    checks++; if (seenQ.size() !== expQ.size()) begin errors++; $display("FAIL rst_fresh_len: got %0d want %0d", seenQ.size(), expQ.size()); end
    else for (int i = 0; i < expQ.size(); i++) begin
      checks++; if (seenQ[i] !== expQ[i]) begin errors++; $display("FAIL rst_fresh_cmd[%0d]: got %h want %h", i, seenQ[i], expQ[i]); end
    end
    checks++; if (sat_result !== 1'b1) begin errors++; $display("FAIL rst_fresh_sat: got %b want 1", sat_result); end
  endtask

  // Back-to-back five-literal runs walk the FIFO pointers past their wrap point.
  task automatic test_back_to_back();
    bit ok, okd;
    bit wants [3] = '{1'b1, 1'b0, 1'b1};
    int base;
    for (int r = 0; r < 3; r++) begin
      fLen = 5;
      for (int i = 0; i < 5; i++) setLit(i, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'(i == 2), 1'(i == 4));
      buildModel();
      armRun(wants[r]);
      pushRange(0, 5, 1'b0, ok);
      base = doneCnt;
      pulseStart();
      waitDone(base, okd);
      repeat (3) @(negedge clk);
      checks++; if (!(ok && okd)) begin errors++; $display("FAIL b2b%0d_timeout: push %b done %b want 1 1", r, ok, okd); end
      checks++; if (seenQ.size() !== expQ.size()) begin errors++; $display("FAIL b2b%0d_len: got %0d want %0d", r, seenQ.size(), expQ.size()); end
      else for (int i = 0; i < expQ.size(); i++) begin
        checks++; if (seenQ[i] !== expQ[i]) begin errors++; $display("FAIL b2b%0d_cmd[%0d]: got %h want %h", r, i, seenQ[i], expQ[i]); end
      end
      checks++; if (sat_result !== wants[r]) begin errors++; $display("FAIL b2b%0d_sat_hold: got %b want %b", r, sat_result, wants[r]); end
      checks++; if (doneCnt - base !== 1) begin errors++; $display("FAIL b2b%0d_done_count: got %0d want 1", r, doneCnt - base); end
    end
  endtask

  task automatic test_random();
    bit ok, ok2, okd, want;
    int base, pre;
    for (int r = 0; r < 6; r++) begin
      fLen = $urandom_range(1, 10);
      for (int i = 0; i < fLen; i++) setLit(i, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), 1'b0);
      fEof[fLen-1] = 1'b1;
      fEoc[fLen-1] = 1'($urandom_range(0, 1));
      want = 1'($urandom_range(0, 1));
      pre = $urandom_range(0, fLen);
      if (pre > DEPTH) pre = DEPTH;
      buildModel();
      armRun(want);
      pushRange(0, pre, 1'b0, ok);
      base = doneCnt;
      pulseStart();
      pushRange(pre, fLen, 1'b1, ok2);
      waitDone(base, okd);
      repeat (2) @(negedge clk);
      checks++; if (!(ok && ok2 && okd)) begin errors++; $display("FAIL rnd%0d_timeout: push %b %b done %b want 1 1 1", r, ok, ok2, okd); end
      checks++; if (seenQ.size() !== expQ.size()) begin errors++; $display("FAIL rnd%0d_len: got %0d want %0d", r, seenQ.size(), expQ.size()); end
      else for (int i = 0; i < expQ.size(); i++) begin
        checks++; if (seenQ[i] !== expQ[i]) begin errors++; $display("FAIL rnd%0d_cmd[%0d]: got %h want %h", r, i, seenQ[i], expQ[i]); end
      end
      checks++; if (sat_result !== want) begin errors++; $display("FAIL rnd%0d_sat: got %b want %b", r, sat_result, want); end
      checks++; if (doneCyc - endcCyc !== LAT + 1) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", r, doneCyc - endcCyc, LAT + 1); end
    end
  endtask

  initial begin
    test_reset();
    test_single_clause();
    test_two_clauses();
    test_fifo_full();
    test_start_while_busy();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
